risc_top: RTL and testbench
===========================

RISC_TOP -- requirements
Module: risc_top

Interface
REQ-001 Parameters SHALL be: ISA_WIDTH, 16, instruction width; REG_DATA_WIDTH, 16, register width; REG_ADDR_WIDTH, 4, register index width (16 registers); MEM_ADDR_WIDTH, 5, data/instruction address width (32 words); MEM_DATA_WIDTH, 16, data RAM word width.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 inst_wen  input  1  program-load enable; when high, the core loads instructions and does not execute.
REQ-005 input_inst  input  ISA_WIDTH  instruction word written during program load.
REQ-006 The block SHALL have no outputs; the bench SHALL observe internal state hierarchically: regfile[0:15], dmem[0:31], imem[0:31], acc, pc, prog_len.

Function
REQ-007 Program load: at each rising edge with rst=1 and inst_wen=1, imem[wptr] SHALL take input_inst, wptr SHALL increment (5-bit, wraps 31->0), and prog_len SHALL take wptr+1 (saturating at 32).
REQ-008 wptr SHALL restart at 0 on the first load edge after an edge with inst_wen=0 or after reset, so each load burst overwrites the program from address 0.
REQ-009 Execution: at each rising edge with rst=1, inst_wen=0 and pc<prog_len, the core SHALL execute imem[pc] in a single cycle and pc SHALL increment by 1.
REQ-010 When pc>=prog_len the core SHALL halt: pc holds and no state changes.
REQ-011 While inst_wen=1, pc, regfile, dmem and acc SHALL hold.
REQ-012 Decode SHALL use op=[15:13] and rd=[12:9]; ra=[8:5].
REQ-013 op 000 LOAD SHALL set regfile[rd] = dmem[(regfile[ra]+[4:0]) mod 32].
REQ-014 op 001 STORE SHALL set dmem[regfile[ra][4:0]] = regfile[[4:1]], ignoring [12:9] and [0].
REQ-015 op 010 MOVE SHALL set regfile[rd] = zero-extended [8:0].
REQ-016 op 011 MAC with [0]=1 SHALL set acc = regfile[ra] and leave regfile unchanged.
REQ-017 op 011 MAC with [0]=0 SHALL compute r = regfile[ra]*regfile[[4:1]] + acc, truncated to 16 bits; both acc and regfile[rd] SHALL take r on the same edge.
REQ-018 op 100-111 SHALL be NOPs that only advance pc.
REQ-019 regfile[0] SHALL always read 0; writes to r0 SHALL be discarded.
REQ-020 Register and dmem reads SHALL be combinational and writes SHALL be synchronous.
REQ-021 There SHALL be no hazards: the state written by instruction N SHALL be visible to instruction N+1.

Reset
REQ-022 On rst=0, the following SHALL clear immediately: pc=0, wptr=0, acc=0, all regfile=0, all dmem=0.
REQ-023 imem and prog_len SHALL NOT be affected by reset, so a loaded program survives reset; prog_len SHALL power up as 0.
REQ-024 Reset asserted mid-load or mid-execution SHALL abort the operation and restart execution at pc=0 after release.

Configuration
REQ-025 When the macro MAC_SAT_EN is defined, the MAC result SHALL saturate to 16'hFFFF if the true sum exceeds 65535.
REQ-026 When MAC_SAT_EN is not defined, the MAC result SHALL wrap modulo 2^16.

Verification
REQ-027 Load the 14-word program {MOVE r1,1; MAC r6,r1,bias; MOVE r2,15; MOVE r3,31; STORE r1,r2; LOAD r4,r1,0; STORE r2,r3; LOAD r5,r1,14; MAC r6,r2,r3; MAC r6,r2,r2; MOVE r7,2; MOVE r8,3; MAC r6,r7,r8; STORE r0,r6}, pulse rst low, then run 14 cycles -> required final state: r4=15, r5=31, r6=697, acc=697, dmem[0]=697, dmem[1]=15, dmem[15]=31.
REQ-028 After the program above, run 5 further cycles -> pc SHALL hold at 14 and all state SHALL remain unchanged.
REQ-029 Reset low for 1 cycle after the program completes -> regfile, dmem and acc SHALL be cleared, imem SHALL be intact, and a rerun SHALL give the same results.
REQ-030 MOVE r0,5 followed by STORE r0,r0 -> r0 SHALL read 0 and dmem[0] SHALL be 0.
REQ-031 Set acc=65535 via MOVE/MAC-bias is not possible (MOVE is 9-bit), so instead set r1=255 and r2=257 with acc=1, then MAC r3,r1,r2 -> r3 SHALL be 0 (wrap) without MAC_SAT_EN and 16'hFFFF with MAC_SAT_EN.
REQ-032 LOAD with regfile[ra]=31 and imm=2 -> address SHALL wrap to dmem[1].

Source files
------------

// File: rtl/risc_top.sv
// Single-cycle 16-bit core: program-load port, 16x16 register file (r0 = 0), 32-word data RAM, MAC accumulator.
// Define MAC_SAT_EN to saturate MAC results at 16'hFFFF instead of wrapping.
module risc_top #(
    parameter int ISA_WIDTH      = 16,
    parameter int REG_DATA_WIDTH = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int MEM_DATA_WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 inst_wen,
    input logic [ISA_WIDTH-1:0] input_inst
);
    localparam int NUM_REGS  = 1 << REG_ADDR_WIDTH;
    localparam int MEM_WORDS = 1 << MEM_ADDR_WIDTH;
    localparam int CNT_W     = MEM_ADDR_WIDTH + 1;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_MOVE  = 3'b010;
    localparam logic [2:0] OP_MAC   = 3'b011;

    logic [ISA_WIDTH-1:0]      imem    [0:MEM_WORDS-1];
    logic [REG_DATA_WIDTH-1:0] regfile [0:NUM_REGS-1];
    logic [MEM_DATA_WIDTH-1:0] dmem    [0:MEM_WORDS-1];
    logic [REG_DATA_WIDTH-1:0] acc;
    logic [CNT_W-1:0]          pc;
    logic [CNT_W-1:0]          prog_len;
    logic [MEM_ADDR_WIDTH-1:0] wptr;
    logic                      loading;

    logic                      exec;
    logic [ISA_WIDTH-1:0]      inst;
    logic [2:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [REG_ADDR_WIDTH-1:0] rb;
    logic [REG_DATA_WIDTH-1:0] ra_val;
    logic [REG_DATA_WIDTH-1:0] rb_val;
    logic [REG_DATA_WIDTH-1:0] mac_res;
    logic [MEM_ADDR_WIDTH-1:0] ld_addr;
    logic [MEM_ADDR_WIDTH-1:0] st_addr;

    assign exec    = (pc < prog_len);
    assign inst    = imem[pc[MEM_ADDR_WIDTH-1:0]];
    assign op      = inst[15:13];
    assign rd      = inst[12:9];
    assign ra      = inst[8:5];
    assign rb      = inst[4:1];
    // r0 is forced to zero on the read side so it never needs write protection for correctness
    assign ra_val  = (ra == '0) ? '0 : regfile[ra];
    assign rb_val  = (rb == '0) ? '0 : regfile[rb];
    assign ld_addr = ra_val[MEM_ADDR_WIDTH-1:0] + inst[MEM_ADDR_WIDTH-1:0];
    assign st_addr = ra_val[MEM_ADDR_WIDTH-1:0];

`ifdef MAC_SAT_EN
    function automatic logic [REG_DATA_WIDTH-1:0] mac_sat(input logic [2*REG_DATA_WIDTH:0] sum);
        return (sum[2*REG_DATA_WIDTH:REG_DATA_WIDTH] != '0) ? '1 : sum[REG_DATA_WIDTH-1:0];
    endfunction

    logic [2*REG_DATA_WIDTH:0] mac_sum;
    assign mac_sum = {{(REG_DATA_WIDTH+1){1'b0}}, ra_val} * {{(REG_DATA_WIDTH+1){1'b0}}, rb_val}
                   + {{(REG_DATA_WIDTH+1){1'b0}}, acc};
    assign mac_res = mac_sat(mac_sum);
`else
    assign mac_res = ra_val * rb_val + acc;
`endif

    // imem and prog_len are deliberately left out of the reset branch so a loaded program survives reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            wptr    <= '0;
            loading <= 1'b0;
            acc     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
            for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= '0;
        end else if (inst_wen) begin
            imem[wptr] <= input_inst;
            wptr       <= wptr + MEM_ADDR_WIDTH'(1);
            loading    <= 1'b1;
            if (!loading)
                prog_len <= CNT_W'(1);
            else if (prog_len != CNT_W'(MEM_WORDS))
                prog_len <= {1'b0, wptr} + CNT_W'(1);
        end else begin
            wptr    <= '0;
            loading <= 1'b0;
            if (exec) begin
                pc <= pc + CNT_W'(1);
                case (op)
                    OP_LOAD: begin
                        if (rd != '0) regfile[rd] <= dmem[ld_addr];
                    end
                    OP_STORE: begin
                        dmem[st_addr] <= rb_val;
                    end
                    OP_MOVE: begin
                        if (rd != '0) regfile[rd] <= {{(REG_DATA_WIDTH-9){1'b0}}, inst[8:0]};
                    end
                    OP_MAC: begin
                        if (inst[0]) begin
                            acc <= ra_val;
                        end else begin
                            acc <= mac_res;
                            if (rd != '0) regfile[rd] <= mac_res;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_risc_top.sv
// Bench for risc_top: directed programs plus random programs, checked against an instruction-level model.
module tb_risc_top;
    logic        clk;
    logic        rst;
    logic        inst_wen;
    logic [15:0] input_inst;

    int vectors;
    int miscompares;

    int m_rf [16];
    int m_dm [32];
    int m_imem [32];
    int m_acc;
    int m_pc;
    int m_plen;

    risc_top dut (
        .clk        (clk),
        .rst        (rst),
        .inst_wen   (inst_wen),
        .input_inst (input_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int enc_move(int rd, int imm);
        return (2 << 13) | (rd << 9) | (imm & 511);
    endfunction
    function automatic int enc_mac(int rd, int ra, int rb);
        return (3 << 13) | (rd << 9) | (ra << 5) | (rb << 1);
    endfunction
    function automatic int enc_bias(int ra);
        return (3 << 13) | (ra << 5) | 1;
    endfunction
    function automatic int enc_store(int ra, int rb);
        return (1 << 13) | (ra << 5) | (rb << 1);
    endfunction
    function automatic int enc_load(int rd, int ra, int imm);
        return (rd << 9) | (ra << 5) | (imm & 31);
    endfunction

    function automatic int rr(int i);
        return (i == 0) ? 0 : m_rf[i];
    endfunction

    task automatic model_reset();
        m_pc  = 0;
        m_acc = 0;
        foreach (m_rf[i]) m_rf[i] = 0;
        foreach (m_dm[i]) m_dm[i] = 0;
    endtask

    task automatic model_step();
        int ins, op, rd, ra, rb, r;
        longint s;
        if (m_pc >= m_plen) return;
        ins = m_imem[m_pc];
        op  = (ins >> 13) & 7;
        rd  = (ins >> 9) & 15;
        ra  = (ins >> 5) & 15;
        rb  = (ins >> 1) & 15;
        case (op)
            0: if (rd != 0) m_rf[rd] = m_dm[(rr(ra) + (ins & 31)) % 32];
            1: m_dm[rr(ra) % 32] = rr(rb);
            2: if (rd != 0) m_rf[rd] = ins & 511;
            3: begin
                if ((ins & 1) != 0) begin
                    m_acc = rr(ra);
                end else begin
                    s = longint'(rr(ra)) * longint'(rr(rb)) + longint'(m_acc);
`ifdef MAC_SAT_EN
                    r = (s > 65535) ? 65535 : int'(s);
`else
                    r = int'(s % 65536);
`endif
                    m_acc = r;
                    if (rd != 0) m_rf[rd] = r;
                end
            end
            default: ;
        endcase
        m_pc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input int prog[$]);
        inst_wen = 1'b1;
        foreach (prog[i]) begin
            input_inst = 16'(prog[i]);
            tick();
            m_imem[i % 32] = prog[i] & 16'hFFFF;
            m_plen = (i + 1 > 32) ? 32 : i + 1;
        end
        inst_wen = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            model_step();
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) chk($sformatf("%s r%0d", tag, i), 32'(dut.regfile[i]), 32'(rr(i)));
        for (int i = 0; i < 32; i++) chk($sformatf("%s dmem%0d", tag, i), 32'(dut.dmem[i]), 32'(m_dm[i]));
        for (int i = 0; i < m_plen; i++) chk($sformatf("%s imem%0d", tag, i), 32'(dut.imem[i]), 32'(m_imem[i]));
        chk({tag, " acc"}, 32'(dut.acc), 32'(m_acc));
        chk({tag, " pc"}, 32'(dut.pc), 32'(m_pc));
        chk({tag, " prog_len"}, 32'(dut.prog_len), 32'(m_plen));
    endtask

    initial begin
        int prog[$];
        int len;
        vectors     = 0;
        miscompares = 0;
        m_plen      = 0;
        foreach (m_imem[i]) m_imem[i] = 0;
        model_reset();
        rst        = 1'b0;
        inst_wen   = 1'b0;
        input_inst = '0;

        #2;
        chk("reset pc", 32'(dut.pc), 32'd0);
        chk("reset acc", 32'(dut.acc), 32'd0);
        for (int i = 0; i < 16; i++) chk($sformatf("reset r%0d", i), 32'(dut.regfile[i]), 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("reset dmem%0d", i), 32'(dut.dmem[i]), 32'd0);
        tick();
        rst = 1'b1;

        // reference program
        prog = '{enc_move(1, 1), enc_bias(1), enc_move(2, 15), enc_move(3, 31), enc_store(1, 2),
                 enc_load(4, 1, 0), enc_store(2, 3), enc_load(5, 1, 14), enc_mac(6, 2, 3),
                 enc_mac(6, 2, 2), enc_move(7, 2), enc_move(8, 3), enc_mac(6, 7, 8), enc_store(0, 6)};
        load_prog(prog);
        pulse_reset();
        run(14);
        chk("prog r4", 32'(dut.regfile[4]), 32'd15);
        chk("prog r5", 32'(dut.regfile[5]), 32'd31);
        chk("prog r6", 32'(dut.regfile[6]), 32'd697);
        chk("prog acc", 32'(dut.acc), 32'd697);
        chk("prog dmem0", 32'(dut.dmem[0]), 32'd697);
        chk("prog dmem1", 32'(dut.dmem[1]), 32'd15);
        chk("prog dmem15", 32'(dut.dmem[15]), 32'd31);
        check_all("prog");

        run(5);
        chk("halt pc", 32'(dut.pc), 32'd14);
        check_all("halt");

        pulse_reset();
        check_all("rerun-reset");
        run(14);
        chk("rerun r6", 32'(dut.regfile[6]), 32'd697);
        chk("rerun dmem0", 32'(dut.dmem[0]), 32'd697);
        check_all("rerun");

        // loading mid-execution freezes state, new program restarts at address 0
        pulse_reset();
        run(5);
        load_prog('{enc_move(9, 100)});
        check_all("midload");
        run(3);
        check_all("midload-halt");
        pulse_reset();
        run(1);
        chk("midload r9", 32'(dut.regfile[9]), 32'd100);

        load_prog('{enc_move(1, 9), enc_store(0, 1), enc_move(0, 5), enc_store(0, 0)});
        pulse_reset();
        run(2);
        chk("r0 pre dmem0", 32'(dut.dmem[0]), 32'd9);
        run(2);
        chk("r0 read", 32'(dut.regfile[0]), 32'd0);
        chk("r0 dmem0", 32'(dut.dmem[0]), 32'd0);
        check_all("r0");

        load_prog('{enc_move(1, 255), enc_move(2, 257), enc_move(4, 1), enc_bias(4), enc_mac(3, 1, 2)});
        pulse_reset();
        run(5);
`ifdef MAC_SAT_EN
        chk("mac overflow r3", 32'(dut.regfile[3]), 32'hFFFF);
`else
        chk("mac overflow r3", 32'(dut.regfile[3]), 32'd0);
`endif
        check_all("macovf");

        load_prog('{enc_move(1, 31), enc_move(2, 77), enc_move(3, 1), enc_store(3, 2), enc_load(4, 1, 2)});
        pulse_reset();
        run(5);
        chk("load wrap r4", 32'(dut.regfile[4]), 32'd77);
        check_all("ldwrap");

        for (int t = 0; t < 10; t++) begin
            len = (t == 3) ? 33 : int'($urandom_range(1, 20));
            prog.delete();
            for (int k = 0; k < len; k++)
                prog.push_back(int'(($urandom_range(0, 4) << 13) | ($urandom & 32'h1FFF)));
            load_prog(prog);
            pulse_reset();
            if ($urandom_range(0, 1) == 1) begin
                run(int'($urandom_range(1, len)));
                pulse_reset();
            end
            run(len + 2);
            check_all($sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
